// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: parametrised register file with write-through bypass and a per-register
// scoreboard of in-flight writes that drives decode busy flags and the issue stall.
module regfile_scoreboard #(
   parameter int XLEN = 64,
   parameter int NREGS = 15,
   parameter int AW = 4,
   parameter logic [AW-1:0] RNONE = 4'hF,
   parameter int CNTW = 2,
   parameter bit STALL_ON_BUSY = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   d_srcA,
   input  logic [AW-1:0]   d_srcB,
   output logic [XLEN-1:0] d_rvalA,
   output logic [XLEN-1:0] d_rvalB,
   output logic            d_busyA,
   output logic            d_busyB,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_dstE,
   input  logic [AW-1:0]   issue_dstM,
   output logic            d_stall,
   input  logic            W_valid,
   input  logic [AW-1:0]   W_dstE,
   input  logic [XLEN-1:0] W_valE,
   input  logic [AW-1:0]   W_dstM,
   input  logic [XLEN-1:0] W_valM
);
   logic [XLEN-1:0] regs [NREGS];
   logic [CNTW-1:0] cnt [NREGS];
   logic [NREGS-1:0] retire, issue, busy, sat;
   logic vSrcA, vSrcB, vWE, vWM, vIE, vIM, full, fire;

   function automatic logic isValid(input logic [AW-1:0] idx);
      return (32'(idx) < NREGS) && (idx != RNONE);
   endfunction

   assign vSrcA = isValid(d_srcA);
   assign vSrcB = isValid(d_srcB);
   assign vWE = isValid(W_dstE);
   assign vWM = isValid(W_dstM);
   assign vIE = isValid(issue_dstE);
   assign vIM = isValid(issue_dstM);

   // Sets are bit vectors, so a shared E/M destination counts once.
   always_comb begin
      for (int i = 0; i < NREGS; i++) begin
         retire[i] = W_valid && ((vWE && W_dstE == AW'(i)) || (vWM && W_dstM == AW'(i)));
         issue[i] = (vIE && issue_dstE == AW'(i)) || (vIM && issue_dstM == AW'(i));
         busy[i] = cnt[i] > CNTW'(retire[i]);
         sat[i] = &cnt[i];
      end
   end

   assign full = |(issue & ~retire & sat);
   assign d_busyA = !reset && vSrcA && busy[d_srcA];
   assign d_busyB = !reset && vSrcB && busy[d_srcB];
   assign d_stall = !reset && issue_valid && (full || (STALL_ON_BUSY && (d_busyA || d_busyB)));
   assign fire = issue_valid && !d_stall;

   // M beats E on a shared destination, both for bypass and for the stored value.
   assign d_rvalA = reset ? '0
                  : (W_valid && vWM && d_srcA == W_dstM) ? W_valM
                  : (W_valid && vWE && d_srcA == W_dstE) ? W_valE
                  : vSrcA ? regs[d_srcA] : '0;
   assign d_rvalB = reset ? '0
                  : (W_valid && vWM && d_srcB == W_dstM) ? W_valM
                  : (W_valid && vWE && d_srcB == W_dstE) ? W_valE
                  : vSrcB ? regs[d_srcB] : '0;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREGS; i++) begin
         if (reset) begin
            regs[i] <= '0;
            cnt[i] <= '0;
         end else begin
            if (W_valid && vWM && W_dstM == AW'(i)) regs[i] <= W_valM;
            else if (W_valid && vWE && W_dstE == AW'(i)) regs[i] <= W_valE;
            if (fire && issue[i] && !retire[i] && !sat[i]) cnt[i] <= cnt[i] + 1'b1;
            else if (retire[i] && !(fire && issue[i]) && cnt[i] != '0) cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end

   for (genvar i = 0; i < NREGS; i++) begin : gChk
      assert property (@(posedge clk) disable iff (reset)
         !(retire[i] && !(fire && issue[i]) && cnt[i] == '0));
   end
endmodule
